// File: rtl/ps2_key_loader.sv
// Collects hex digits typed on a PS/2 keyboard into a key register.
// Break and extended prefixes are filtered; Enter commits a full key.
module ps2_key_loader #(
   parameter int DIGITS = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         rx_done_tick,
   input  logic [7:0]   rx_code,
   output logic         rx_en,
   output logic [127:0] key_out,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [5:0]   digit_cnt,
   output logic         err_tick
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      EXT     = 3'd2,
      SKIP    = 3'd3,
      HOLD    = 3'd4
   } state_t;

   localparam logic [7:0] C_BKSP  = 8'h66;
   localparam logic [7:0] C_ESC   = 8'h76;
   localparam logic [7:0] C_ENTER = 8'h5A;
   localparam logic [7:0] C_BREAK = 8'hF0;
   localparam logic [7:0] C_EXT   = 8'hE0;

   localparam logic [5:0] FULL = 6'(DIGITS);

   // Only the low DIGITS nibbles of a key are meaningful
   localparam logic [127:0] KEY_MASK =
      (DIGITS >= 32) ? {128{1'b1}}
                     : ((128'd1 << (4 * DIGITS)) - 128'd1);

   state_t         state_q, state_d;
   logic [127:0]   buf_q, buf_d;
   logic [127:0]   key_q, key_d;
   logic [5:0]     cnt_q, cnt_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;

   logic           hex_hit;
   logic [3:0]     hex_nib;
   logic           is_full;
   logic           is_empty;

   always_comb begin
      hex_hit = 1'b1;
      hex_nib = 4'h0;
      case (rx_code)
         8'h45: hex_nib = 4'h0;
         8'h16: hex_nib = 4'h1;
         8'h1E: hex_nib = 4'h2;
         8'h26: hex_nib = 4'h3;
         8'h25: hex_nib = 4'h4;
         8'h2E: hex_nib = 4'h5;
         8'h36: hex_nib = 4'h6;
         8'h3D: hex_nib = 4'h7;
         8'h3E: hex_nib = 4'h8;
         8'h46: hex_nib = 4'h9;
         8'h1C: hex_nib = 4'hA;
         8'h32: hex_nib = 4'hB;
         8'h21: hex_nib = 4'hC;
         8'h23: hex_nib = 4'hD;
         8'h24: hex_nib = 4'hE;
         8'h2B: hex_nib = 4'hF;
         default: hex_hit = 1'b0;
      endcase
   end

   assign is_full  = (cnt_q == FULL);
   assign is_empty = (cnt_q == 6'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         buf_q   <= '0;
         key_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = COLLECT;
         end
         COLLECT: begin
            if (rx_done_tick) begin
               if (rx_code == C_BREAK)
                  state_d = SKIP;
               else if (rx_code == C_EXT)
                  state_d = EXT;
               else if (rx_code == C_ENTER && is_full)
                  state_d = HOLD;
            end
         end
         EXT: begin
            if (rx_done_tick)
               state_d = (rx_code == C_BREAK) ? SKIP : COLLECT;
         end
         SKIP: begin
            if (rx_done_tick) state_d = COLLECT;
         end
         HOLD: begin
            if (key_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      err_d   = 1'b0;
      valid_d = (state_d == HOLD);
      if (state_q == IDLE && start) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (state_q == COLLECT && rx_done_tick) begin
         if (hex_hit) begin
            if (!is_full) begin
               buf_d = {buf_q[123:0], hex_nib};
               cnt_d = cnt_q + 6'd1;
            end
         end else if (rx_code == C_BKSP) begin
            if (!is_empty) begin
               buf_d = {4'h0, buf_q[127:4]};
               cnt_d = cnt_q - 6'd1;
            end
         end else if (rx_code == C_ESC) begin
            buf_d = '0;
            cnt_d = '0;
         end else if (rx_code == C_ENTER) begin
            if (is_full)
               key_d = buf_q & KEY_MASK;
            else
               err_d = 1'b1;
         end
      end
   end

   assign rx_en     = (state_q == COLLECT) ||
                      (state_q == EXT) ||
                      (state_q == SKIP);
   assign key_out   = key_q;
   assign key_valid = valid_q;
   assign digit_cnt = cnt_q;
   assign err_tick  = err_q;

endmodule
